approx_mul_err_acc: RTL

APPROX_MUL_ERR_ACC -- requirements
Module: approx_mul_err_acc

---
 rtl/approx_mul_err_acc.sv | 109 ++++++++++
 1 files changed

// File: rtl/approx_mul_err_acc.sv
// Error statistics for an approximate multiplier: streams N operand pairs,
// compares each approximate product against the exact one, and accumulates sum/max/count of |error|.
module approx_mul_err_acc #(
   parameter int N_LOG2 = 8,
   parameter int WIDTH  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          op_a,
   input  logic [WIDTH-1:0]          op_b,
   input  logic [2*WIDTH-1:0]        approx_prod,
   output logic                      busy,
   output logic                      done,
   output logic [2*WIDTH+N_LOG2-1:0] sum_err,
   output logic [2*WIDTH-1:0]        mae,
   output logic [2*WIDTH-1:0]        max_err,
   output logic [N_LOG2:0]           err_cnt
);

   localparam int PW = 2 * WIDTH;
   localparam int SW = PW + N_LOG2;
   localparam int CW = N_LOG2 + 1;
   localparam logic [CW-1:0] N_CNT    = CW'(1 << N_LOG2);
   localparam logic [CW-1:0] LAST_IDX = CW'((1 << N_LOG2) - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   sample_cnt;
   logic            accept, last_accept, clear;
   logic            s1_valid, s2_valid;
   logic [PW-1:0]   s1_exact, s1_approx, s2_err;

   assign accept      = in_valid && in_ready;
   assign last_accept = accept && (sample_cnt == LAST_IDX);
   assign clear       = start && ((state == IDLE) || (state == DONE));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; DRAIN ends once stage 1 is empty, so the final
   // accumulate lands on the same edge that enters DONE.
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      unique case (state)
         IDLE:    if (start)       state_nxt = RUN;
         RUN:     if (last_accept) state_nxt = DRAIN;
         DRAIN:   if (!s1_valid)   state_nxt = DONE;
         DONE:    if (start)       state_nxt = RUN;
         default:                  state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready = (state == RUN) && (sample_cnt < N_CNT);
      busy     = (state == RUN) || (state == DRAIN);
      done     = (state == DONE);
   end

   // NOTE: pure datapath registers carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_exact  <= PW'(op_a) * PW'(op_b);
         s1_approx <= approx_prod;
      end
      if (s1_valid)
         s2_err <= (s1_exact >= s1_approx) ? s1_exact - s1_approx : s1_approx - s1_exact;
   end

   // Valid bits, sample counter and accumulators
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         sample_cnt <= '0;
         sum_err    <= '0;
         max_err    <= '0;
         err_cnt    <= '0;
      end else begin
         s1_valid <= accept;
         s2_valid <= s1_valid;
         if (clear) begin
            sample_cnt <= '0;
            sum_err    <= '0;
            max_err    <= '0;
            err_cnt    <= '0;
         end else begin
            if (accept)
               sample_cnt <= sample_cnt + CW'(1);
            if (s2_valid) begin
               sum_err <= sum_err + SW'(s2_err);
               if (s2_err > max_err) max_err <= s2_err;
               if (s2_err != '0)     err_cnt <= err_cnt + CW'(1);
            end
         end
      end
   end

   assign mae = sum_err[SW-1:N_LOG2];

endmodule
